// File: rtl/debayer_pkg.sv
// debayer_pkg: shared types and constants for the debayer capture sequencer.
//   state_t       - sequencer FSM states
//   frame_error_t - frame_error_out encoding
//   DUMMY_BORDER  - dummy rows/columns the debayer consumes on each axis
//   sat_inc       - saturating increment for the 11-bit geometry counters
package debayer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_LINE_COUNT  = 2'd1,
    ERR_LINE_LENGTH = 2'd2,
    ERR_TIMEOUT     = 2'd3
  } frame_error_t;

  localparam int DUMMY_BORDER = 2;
  localparam int CNT_W        = 11;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/debayer_geometry_checker.sv
// debayer_geometry_checker: measures the debayer RGB output geometry.
// Ports:
//   clk, rst_n      - pixel clock, async active-low reset
//   enable          - count only while the sequencer is in CAPTURE or DRAIN
//   clear           - restart all counters/flags (start of a new capture)
//   x_parity        - latched x crop parity (expected width shrinks by 1)
//   y_parity        - latched y crop parity (expected height shrinks by 1)
//   rgb_line_valid  - debayer line_valid output
//   length_error    - some line so far (including this cycle) had a bad length
//   count_error     - line total so far (including this cycle) != expected
module debayer_geometry_checker
  import debayer_pkg::*;
#(
  parameter int WIDTH  = 1288,
  parameter int HEIGHT = 728
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  input  logic x_parity,
  input  logic y_parity,
  input  logic rgb_line_valid,
  output logic length_error,
  output logic count_error
);

  localparam logic [CNT_W-1:0] BASE_W = CNT_W'(WIDTH - DUMMY_BORDER);
  localparam logic [CNT_W-1:0] BASE_H = CNT_W'(HEIGHT - DUMMY_BORDER);

  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] exp_w;
  logic [CNT_W-1:0] exp_h;
  logic [CNT_W-1:0] line_total;
  logic             lv_q;
  logic             line_end;
  logic             len_bad_now;
  logic             len_err_q;

  assign exp_w = BASE_W - {{(CNT_W-1){1'b0}}, x_parity};
  assign exp_h = BASE_H - {{(CNT_W-1){1'b0}}, y_parity};

  // The verdicts include the current cycle so a line ending on the very
  // cycle the sequencer evaluates is still counted.
  assign line_end     = enable & lv_q & ~rgb_line_valid;
  assign len_bad_now  = line_end & (pix_cnt != exp_w);
  assign length_error = len_err_q | len_bad_now;
  assign line_total   = line_end ? sat_inc(line_cnt) : line_cnt;
  assign count_error  = (line_total != exp_h);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt   <= '0;
      line_cnt  <= '0;
      lv_q      <= 1'b0;
      len_err_q <= 1'b0;
    end else if (clear) begin
      pix_cnt   <= '0;
      line_cnt  <= '0;
      lv_q      <= 1'b0;
      len_err_q <= 1'b0;
    end else if (enable) begin
      lv_q <= rgb_line_valid;
      if (rgb_line_valid) begin
        pix_cnt <= sat_inc(pix_cnt);
      end
      if (line_end) begin
        pix_cnt  <= '0;
        line_cnt <= sat_inc(line_cnt);
        if (len_bad_now) begin
          len_err_q <= 1'b1;
        end
      end
    end else begin
      lv_q <= 1'b0;
    end
  end

endmodule

// File: rtl/debayer_capture_sequencer.sv
// debayer_capture_sequencer: passes exactly one whole sensor frame into the
// debayer per capture request and reports completion / geometry errors.
// Optional watchdog: define DEBAYER_CAPTURE_SEQUENCER_TIMEOUT_EN.
// Ports:
//   pixel_clock_in, pixel_reset_n_in - clock, async active-low reset
//   capture_in                       - 1-cycle capture request (synchronous)
//   x/y_crop_start_lsb_cfg_in        - requested crop parities
//   bayer_data_in, line_valid_in, frame_valid_in - sensor stream
//   bayer_data_out, line_valid_out, frame_valid_out - gated stream, 1 cycle late
//   x/y_crop_start_lsb_out           - parities latched at capture
//   rgb_line_valid_in, rgb_frame_valid_in - debayer output strobes
//   busy_out        - not IDLE
//   frame_done_out  - 1-cycle pulse at end of a capture
//   frame_error_out - 0 none, 1 line count, 2 line length, 3 timeout (sticky)
//
// state   | meaning
// IDLE    | waiting for capture_in
// ARMED   | waiting for frame_valid_in low, then its next rising edge
// CAPTURE | gate open, sensor frame flowing into the debayer
// DRAIN   | gate closed, waiting for the debayer to finish its frame
module debayer_capture_sequencer
  import debayer_pkg::*;
#(
  parameter int          WIDTH          = 1288,
  parameter int          HEIGHT         = 728,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic       pixel_clock_in,
  input  logic       pixel_reset_n_in,
  input  logic       capture_in,
  input  logic       x_crop_start_lsb_cfg_in,
  input  logic       y_crop_start_lsb_cfg_in,
  input  logic [9:0] bayer_data_in,
  input  logic       line_valid_in,
  input  logic       frame_valid_in,
  output logic [9:0] bayer_data_out,
  output logic       line_valid_out,
  output logic       frame_valid_out,
  output logic       x_crop_start_lsb_out,
  output logic       y_crop_start_lsb_out,
  input  logic       rgb_line_valid_in,
  input  logic       rgb_frame_valid_in,
  output logic       busy_out,
  output logic       frame_done_out,
  output logic [1:0] frame_error_out
);

  state_t       state, state_next;
  frame_error_t err_q, err_next;
  logic         gate_open;
  logic         done_next;
  logic         load_cfg;
  logic         seen_low;
  logic         rgb_fv_q;
  logic [2:0]   rgb_low_cnt;
  logic         rgb_fall;
  logic         drain_quiet;
  logic         check_en;
  logic         length_error;
  logic         count_error;

  assign rgb_fall    = rgb_fv_q & ~rgb_frame_valid_in;
  assign drain_quiet = ~rgb_frame_valid_in & (rgb_low_cnt == 3'd3);
  assign check_en    = (state == CAPTURE) || (state == DRAIN);

`ifdef DEBAYER_CAPTURE_SEQUENCER_TIMEOUT_EN
  logic [23:0] tmo_cnt;
  logic        tmo_hit;

  assign tmo_hit = (state != IDLE) && (tmo_cnt == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge pixel_clock_in or negedge pixel_reset_n_in) begin
    if (!pixel_reset_n_in) begin
      tmo_cnt <= '0;
    end else if (load_cfg) begin
      tmo_cnt <= '0;
    end else if (state != IDLE) begin
      tmo_cnt <= tmo_cnt + 24'd1;
    end
  end
`endif

  // gate_open is the combinational "frame passes this cycle" decision, so the
  // rising-edge cycle itself is forwarded and the output latency stays 1.
  always_comb begin
    state_next = state;
    err_next   = err_q;
    gate_open  = 1'b0;
    done_next  = 1'b0;
    load_cfg   = 1'b0;
    case (state)
      IDLE: begin
        if (capture_in) begin
          state_next = ARMED;
          err_next   = ERR_NONE;
          load_cfg   = 1'b1;
        end
      end
      ARMED: begin
        if (seen_low && frame_valid_in) begin
          state_next = CAPTURE;
          gate_open  = 1'b1;
        end
      end
      CAPTURE: begin
        if (!frame_valid_in) begin
          state_next = DRAIN;
        end else begin
          gate_open = 1'b1;
        end
      end
      DRAIN: begin
        if (rgb_fall || drain_quiet) begin
          state_next = IDLE;
          done_next  = 1'b1;
          if (length_error) begin
            err_next = ERR_LINE_LENGTH;
          end else if (count_error) begin
            err_next = ERR_LINE_COUNT;
          end else begin
            err_next = ERR_NONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef DEBAYER_CAPTURE_SEQUENCER_TIMEOUT_EN
    if (tmo_hit) begin
      state_next = IDLE;
      gate_open  = 1'b0;
      done_next  = 1'b1;
      err_next   = ERR_TIMEOUT;
    end
`endif
  end

  always_ff @(posedge pixel_clock_in or negedge pixel_reset_n_in) begin
    if (!pixel_reset_n_in) begin
      state                <= IDLE;
      err_q                <= ERR_NONE;
      frame_done_out       <= 1'b0;
      seen_low             <= 1'b0;
      rgb_fv_q             <= 1'b0;
      rgb_low_cnt          <= '0;
      x_crop_start_lsb_out <= 1'b0;
      y_crop_start_lsb_out <= 1'b0;
      bayer_data_out       <= '0;
      line_valid_out       <= 1'b0;
      frame_valid_out      <= 1'b0;
    end else begin
      state          <= state_next;
      err_q          <= err_next;
      frame_done_out <= done_next;
      rgb_fv_q       <= rgb_frame_valid_in;

      if (state != ARMED) begin
        seen_low <= 1'b0;
      end else if (!frame_valid_in) begin
        seen_low <= 1'b1;
      end

      if (state != DRAIN || rgb_frame_valid_in) begin
        rgb_low_cnt <= '0;
      end else if (rgb_low_cnt != 3'd4) begin
        rgb_low_cnt <= rgb_low_cnt + 3'd1;
      end

      if (load_cfg) begin
        x_crop_start_lsb_out <= x_crop_start_lsb_cfg_in;
        y_crop_start_lsb_out <= y_crop_start_lsb_cfg_in;
      end

      bayer_data_out  <= bayer_data_in;
      frame_valid_out <= frame_valid_in & gate_open;
      line_valid_out  <= line_valid_in & frame_valid_in & gate_open;
    end
  end

  assign busy_out        = (state != IDLE);
  assign frame_error_out = err_q;

  debayer_geometry_checker #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_geometry_checker (
    .clk            (pixel_clock_in),
    .rst_n          (pixel_reset_n_in),
    .enable         (check_en),
    .clear          (load_cfg),
    .x_parity       (x_crop_start_lsb_out),
    .y_parity       (y_crop_start_lsb_out),
    .rgb_line_valid (rgb_line_valid_in),
    .length_error   (length_error),
    .count_error    (count_error)
  );

endmodule

// File: tb/tb_debayer_capture_sequencer.sv
// tb_debayer_capture_sequencer: directed bench for debayer_capture_sequencer
// with a 6x4 sensor. Expected frame_error codes are pushed to a queue when a
// captured frame is driven and popped when frame_done_out pulses.
module tb_debayer_capture_sequencer;

  localparam int W_TB = 6;
  localparam int H_TB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       capture_in = 1'b0;
  logic       x_cfg = 1'b0;
  logic       y_cfg = 1'b0;
  logic [9:0] bayer_data_in = '0;
  logic       line_valid_in = 1'b0;
  logic       frame_valid_in = 1'b0;
  logic [9:0] bayer_data_out;
  logic       line_valid_out;
  logic       frame_valid_out;
  logic       x_out;
  logic       y_out;
  logic       rgb_lv = 1'b0;
  logic       rgb_fv = 1'b0;
  logic       busy_out;
  logic       frame_done_out;
  logic [1:0] frame_error_out;

  int         n_checks = 0;
  int         n_fail = 0;
  int         dp_mism = 0;
  int         done_count = 0;
  int         exp_done = 0;
  logic       exp_x = 1'b0;
  logic       exp_y = 1'b0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  debayer_capture_sequencer #(
    .WIDTH          (W_TB),
    .HEIGHT         (H_TB),
    .TIMEOUT_CYCLES (24'd100)
  ) dut (
    .pixel_clock_in          (clk),
    .pixel_reset_n_in        (rst_n),
    .capture_in              (capture_in),
    .x_crop_start_lsb_cfg_in (x_cfg),
    .y_crop_start_lsb_cfg_in (y_cfg),
    .bayer_data_in           (bayer_data_in),
    .line_valid_in           (line_valid_in),
    .frame_valid_in          (frame_valid_in),
    .bayer_data_out          (bayer_data_out),
    .line_valid_out          (line_valid_out),
    .frame_valid_out         (frame_valid_out),
    .x_crop_start_lsb_out    (x_out),
    .y_crop_start_lsb_out    (y_out),
    .rgb_line_valid_in       (rgb_lv),
    .rgb_frame_valid_in      (rgb_fv),
    .busy_out                (busy_out),
    .frame_done_out          (frame_done_out),
    .frame_error_out         (frame_error_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; outputs after the edge must reflect these inputs.
  task automatic step(input logic fv, input logic lv, input logic rfv, input logic rlv,
                      input logic cap, input logic pass);
    logic [9:0] d;
    d = 10'($urandom_range(0, 1023));
    frame_valid_in = fv;
    line_valid_in  = lv;
    rgb_fv         = rfv;
    rgb_lv         = rlv;
    capture_in     = cap;
    bayer_data_in  = d;
    tick();
    capture_in = 1'b0;
    if (frame_valid_out !== (fv & pass) || line_valid_out !== (lv & fv & pass) ||
        bayer_data_out !== d || x_out !== exp_x || y_out !== exp_y)
      dp_mism++;
  endtask

  task automatic check_dp(input string tag);
    check(tag, dp_mism, 0);
    dp_mism = 0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic capture();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Sensor frame of H_TB lines x W_TB pixels. When passed and rgb_on, the
  // debayer model emits rgb_n lines during sensor lines 1..rgb_n (first line
  // len0 pixels, the rest len pixels) and drops frame_valid 2 cycles after
  // the sensor does.
  task automatic send_frame(input bit pass, input int cap_at, input bit rgb_on,
                            input int rgb_n, input int len0, input int len);
    int idx;
    int ew;
    int eh;
    logic [1:0] code;
    logic rfv;
    logic rl;
    idx = 0;
    rfv = pass & rgb_on;
    if (pass) begin
      ew = W_TB - 2 - int'(exp_x);
      eh = H_TB - 2 - int'(exp_y);
      code = 2'd0;
      if ((rgb_on && rgb_n >= 1 && len0 != ew) || (rgb_on && rgb_n >= 2 && len != ew))
        code = 2'd2;
      else if ((rgb_on ? rgb_n : 0) != eh)
        code = 2'd1;
      exp_q.push_back(code);
      exp_done++;
    end
    step(1'b1, 1'b0, rfv, 1'b0, idx == cap_at, pass);
    idx++;
    for (int l = 0; l < H_TB; l++) begin
      for (int c = 0; c < W_TB + 2; c++) begin
        rl = rfv && l >= 1 && l <= rgb_n && c < ((l == 1) ? len0 : len);
        step(1'b1, c < W_TB, rfv, rl, idx == cap_at, pass);
        idx++;
      end
    end
    step(1'b0, 1'b0, rfv, 1'b0, 1'b0, pass);
    step(1'b0, 1'b0, rfv, 1'b0, 1'b0, pass);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pass);
    gap(3);
  endtask

  always @(posedge clk) begin
    #1;
    if (frame_done_out === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0)
        check("done_unexpected", frame_done_out, 0);
      else
        check("frame_error_at_done", frame_error_out, exp_q.pop_front());
    end
  end

  initial begin
    int d0;
    int busy_cnt;

    // Reset values
    bayer_data_in = 10'h3FF;
    x_cfg = 1'b1;
    y_cfg = 1'b1;
    tick();
    tick();
    check("rst_busy", busy_out, 0);
    check("rst_done", frame_done_out, 0);
    check("rst_error", frame_error_out, 0);
    check("rst_fv_out", frame_valid_out, 0);
    check("rst_data_out", bayer_data_out, 0);
    check("rst_x_out", x_out, 0);
    rst_n = 1'b1;
    x_cfg = 1'b0;
    y_cfg = 1'b0;
    gap(2);
    check_dp("idle_datapath");

    // Clean capture, 2 lines of 4 pixels
    capture();
    check("t1_busy_armed", busy_out, 1);
    gap(2);
    send_frame(1'b1, -1, 1'b1, 2, 4, 4);
    check_dp("t1_datapath");
    check("t1_busy_after", busy_out, 0);
    check("t1_error", frame_error_out, 0);

    // Capture mid-frame: that frame is skipped, the next one passes
    send_frame(1'b0, 3, 1'b0, 0, 0, 0);
    check("t2_busy_skipping", busy_out, 1);
    send_frame(1'b1, -1, 1'b1, 2, 4, 4);
    check_dp("t2_datapath");
    check("t2_busy_after", busy_out, 0);

    // Parity 1,1 latched, cfg changed afterwards: 3 pixels x 1 line
    x_cfg = 1'b1;
    y_cfg = 1'b1;
    exp_x = 1'b1;
    exp_y = 1'b1;
    capture();
    x_cfg = 1'b0;
    y_cfg = 1'b0;
    gap(2);
    send_frame(1'b1, -1, 1'b1, 1, 3, 3);
    check_dp("t3_datapath_parity");
    check("t3_x_out", x_out, 1);
    check("t3_y_out", y_out, 1);

    // Short first line -> line length error, sticky
    exp_x = 1'b0;
    exp_y = 1'b0;
    capture();
    gap(2);
    send_frame(1'b1, -1, 1'b1, 2, 3, 4);
    gap(5);
    check("t4_error_sticky", frame_error_out, 2);
    check_dp("t4_datapath");

    // Next capture clears the error; a second capture mid-frame is ignored
    capture();
    check("t5_error_cleared", frame_error_out, 0);
    gap(2);
    d0 = done_count;
    send_frame(1'b1, 10, 1'b1, 2, 4, 4);
    check("t5_single_done", done_count - d0, 1);
    check("t5_busy_after", busy_out, 0);
    check_dp("t5_datapath");

    // Too many lines -> line count error
    capture();
    gap(2);
    send_frame(1'b1, -1, 1'b1, 3, 4, 4);
    check("t6_error", frame_error_out, 1);

    // Debayer never raises frame_valid: drain ends after 4 quiet cycles
    capture();
    gap(2);
    send_frame(1'b1, -1, 1'b0, 0, 0, 0);
    check("t7_busy_after", busy_out, 0);
    check("t7_error", frame_error_out, 1);
    check_dp("t7_datapath");

`ifdef DEBAYER_CAPTURE_SEQUENCER_TIMEOUT_EN
    // No frame arrives: watchdog fires after 100 busy cycles
    exp_q.push_back(2'd3);
    exp_done++;
    capture();
    busy_cnt = busy_out ? 1 : 0;
    for (int i = 0; i < 200 && busy_out; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (busy_out) busy_cnt++;
    end
    check("t8_timeout_busy_cycles", busy_cnt, 100);
    check("t8_timeout_error", frame_error_out, 3);
    check_dp("t8_datapath");
`endif

    // Reset asserted mid-CAPTURE
    x_cfg = 1'b1;
    y_cfg = 1'b1;
    exp_x = 1'b1;
    exp_y = 1'b1;
    capture();
    gap(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_dp("t9_pre_reset");
    check("t9_fv_out_before", frame_valid_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t9_async_fv_out", frame_valid_out, 0);
    check("t9_async_lv_out", line_valid_out, 0);
    check("t9_async_busy", busy_out, 0);
    check("t9_async_x_out", x_out, 0);
    check("t9_async_y_out", y_out, 0);
    check("t9_async_data_out", bayer_data_out, 0);
    exp_x = 1'b0;
    exp_y = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    gap(3);
    check_dp("t9_after_release");
    check("t9_busy_after", busy_out, 0);

    check("total_done_pulses", done_count, exp_done);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
